// File: rtl/button_led_pio_pkg.sv
// -----------------------------------------------------------------------------
// button_led_pio_pkg
// Shared definitions for the button/LED PIO slave:
//   - word addresses of the slave registers
//   - debouncer state encoding
// -----------------------------------------------------------------------------
package button_led_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_LED      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE     = 3'd3;
  localparam logic [2:0] ADDR_DUTY     = 3'd4;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } db_state_e;

endpackage

// File: rtl/pio_debounce.sv
// -----------------------------------------------------------------------------
// pio_debounce
// One button channel: inversion of the active-low pin, 2-flop synchroniser,
// counting debouncer and a one-cycle rise pulse on each accepted press.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   button  in   raw active-low pin (asynchronous)
//   level   out  debounced level, 1 = pressed
//   rise    out  high in the cycle before level goes 0->1
// -----------------------------------------------------------------------------
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic rise
);
  import button_led_pio_pkg::*;

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  db_state_e        state;
  db_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_q;
  logic             level_nxt;

  // Stage p0/p1: synchroniser on the inverted pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= ~button;
      sync_p1 <= sync_p0;
    end
  end

  // Debouncer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= STABLE;
      cnt     <= '0;
      level_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level_q <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_q;
    rise      = 1'b0;
    case (state)
      STABLE: begin
        cnt_nxt = '0;
        if (sync_p1 != level_q) state_nxt = SETTLING;
      end
      SETTLING: begin
        if (sync_p1 == level_q) begin
          cnt_nxt   = '0;
          state_nxt = STABLE;
        end else if (cnt == CNT_LAST) begin
          // Sample held long enough: accept the new level
          level_nxt = ~level_q;
          cnt_nxt   = '0;
          state_nxt = STABLE;
          rise      = ~level_q;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = STABLE;
      end
    endcase
  end

  assign level = level_q;

endmodule

// File: rtl/button_led_pio.sv
// -----------------------------------------------------------------------------
// button_led_pio
// N_CH debounced push-buttons with press capture and maskable interrupt, plus
// N_CH LED outputs, behind a small memory-mapped slave port.
// Optional global PWM dimming of the LEDs is built when LED_PWM_EN is defined;
// otherwise the LEDs follow the LED register directly and DUTY reads 0.
//
// Ports:
//   osc_clk     in   single clock
//   reset       in   asynchronous active-high reset
//   button      in   raw active-low buttons [N_CH]
//   led         out  active-high LED drive [N_CH]
//   address     in   word address [3]
//   chipselect  in   slave select
//   write       in   write strobe
//   writedata   in   write data [32]
//   read        in   read strobe
//   readdata    out  registered read data [32]
//   irq         out  registered level interrupt
// -----------------------------------------------------------------------------
module button_led_pio #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PWM_BITS        = 8
) (
  input  logic            osc_clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] led,
  input  logic [2:0]      address,
  input  logic            chipselect,
  input  logic            write,
  input  logic [31:0]     writedata,
  input  logic            read,
  output logic [31:0]     readdata,
  output logic            irq
);
  import button_led_pio_pkg::*;

  logic [N_CH-1:0]     level;
  logic [N_CH-1:0]     rise;
  logic [N_CH-1:0]     led_reg;
  logic [N_CH-1:0]     mask_reg;
  logic [N_CH-1:0]     edge_reg;
  logic [N_CH-1:0]     edge_clr;
  logic [PWM_BITS-1:0] duty_rd;
  logic [31:0]         rd_data;
  logic                wr_en;
  logic                rd_en;
  logic                unused_wdata;

  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign unused_wdata = ^writedata;

  // Input path: one debouncer per channel
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (osc_clk),
      .rst   (reset),
      .button(button[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[N_CH-1:0] : '0;

  // Register file, edge capture and interrupt
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      led_reg  <= '0;
      mask_reg <= '0;
      edge_reg <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_LED)      led_reg  <= writedata[N_CH-1:0];
      if (wr_en && address == ADDR_IRQ_MASK) mask_reg <= writedata[N_CH-1:0];
      // A new press wins over a simultaneous clear of the same bit
      edge_reg <= (edge_reg & ~edge_clr) | rise;
      irq      <= |(edge_reg & mask_reg);
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] duty_reg;
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      duty_reg <= '1;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (wr_en && address == ADDR_DUTY) duty_reg <= writedata[PWM_BITS-1:0];
    end
  end

  assign duty_rd = duty_reg;
  assign led     = led_reg & {N_CH{pwm_cnt < duty_reg}};
`else
  assign duty_rd = '0;
  assign led     = led_reg;
`endif

  // Read mux; sampled before any same-cycle write lands
  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_DATA:     rd_data[N_CH-1:0]     = level;
      ADDR_LED:      rd_data[N_CH-1:0]     = led_reg;
      ADDR_IRQ_MASK: rd_data[N_CH-1:0]     = mask_reg;
      ADDR_EDGE:     rd_data[N_CH-1:0]     = edge_reg;
      ADDR_DUTY:     rd_data[PWM_BITS-1:0] = duty_rd;
      default:       rd_data               = '0;
    endcase
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_button_led_pio.sv
module tb_button_led_pio;

  localparam int N_CH = 4;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int PWM_BITS = 4;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_LED  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_DUTY = 3'd4;
  localparam logic [2:0] A_RSV  = 3'd5;

  logic            osc_clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] led;
  logic [2:0]      address;
  logic            chipselect;
  logic            write;
  logic [31:0]     writedata;
  logic            read;
  logic [31:0]     readdata;
  logic            irq;

  int checks = 0;
  int failures = 0;

  button_led_pio #(
    .N_CH(N_CH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .PWM_BITS(PWM_BITS)
  ) dut (
    .osc_clk(osc_clk),
    .reset(reset),
    .button(button),
    .led(led),
    .address(address),
    .chipselect(chipselect),
    .write(write),
    .writedata(writedata),
    .read(read),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 osc_clk = ~osc_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    tick();
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  // Continuous read of one address until bit b reads 1; n = ticks taken (0 = never)
  task automatic wait_bit(input logic [2:0] a, input int b, output int n);
    address = a; chipselect = 1'b1; read = 1'b1; n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (readdata[b]) begin
        n = k;
        break;
      end
    end
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] duty_exp;
    reset = 1'b1; button = '1; address = '0; chipselect = 1'b0;
    write = 1'b0; writedata = '0; read = 1'b0;
    tick(); tick();
    checks++;
    if (led !== 4'h0 || readdata !== 32'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: led=%0h readdata=%0h irq=%0b required 0/0/0", led, readdata, irq);
    end
    reset = 1'b0;
    tick();
    bus_read(A_DATA, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_data: got %0h required 0", d); end
    bus_read(A_LED, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_led: got %0h required 0", d); end
    bus_read(A_MASK, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_mask: got %0h required 0", d); end
    bus_read(A_EDGE, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_edge: got %0h required 0", d); end
`ifdef LED_PWM_EN
    duty_exp = 32'hF;
`else
    duty_exp = 32'h0;
`endif
    bus_read(A_DUTY, d); checks++;
    if (d !== duty_exp) begin failures++; $display("FAIL reset_duty: got %0h required %0h", d, duty_exp); end
  endtask

  task automatic test_press();
    int n;
    logic [31:0] d;
    button[2] = 1'b0;
    wait_bit(A_DATA, 2, n);
    checks++;
    if (n != 8) begin failures++; $display("FAIL press_latency: got %0d ticks required 8", n); end
    checks++;
    if (readdata !== 32'h4) begin failures++; $display("FAIL press_data: got %0h required 4", readdata); end
    bus_read(A_EDGE, d); checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL press_edge: got %0h required 4", d); end
    repeat (10) tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL press_irq_masked: got %0b required 0", irq); end
    bus_write(A_EDGE, 32'h4);
    button[2] = 1'b1;
    repeat (12) tick();
    bus_read(A_DATA, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL release_data: got %0h required 0", d); end
    bus_read(A_EDGE, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL release_edge: got %0h required 0", d); end
  endtask

  task automatic test_irq();
    int n;
    logic prev_irq;
    logic [31:0] d;
    bus_write(A_MASK, 32'h4);
    button[2] = 1'b0;
    address = A_EDGE; chipselect = 1'b1; read = 1'b1; n = 0; prev_irq = irq;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (readdata[2]) begin
        n = k;
        break;
      end
      prev_irq = irq;
    end
    chipselect = 1'b0; read = 1'b0;
    checks++;
    if (n != 8 || irq !== 1'b1 || prev_irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_assert: ticks=%0d irq=%0b prev_irq=%0b required 8/1/0", n, irq, prev_irq);
    end
    bus_write(A_EDGE, 32'h4);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold_on_clear: got %0b required 1", irq); end
    tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %0b required 0", irq); end
    bus_read(A_EDGE, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL irq_edge_cleared: got %0h required 0", d); end
    button[2] = 1'b1;
    repeat (12) tick();
    bus_write(A_MASK, 32'h0);
  endtask

  task automatic test_glitch();
    logic seen;
    logic [31:0] d;
    button[0] = 1'b0;
    repeat (3) tick();
    button[0] = 1'b1;
    seen = 1'b0;
    address = A_DATA; chipselect = 1'b1; read = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (readdata !== 32'h0) seen = 1'b1;
    end
    chipselect = 1'b0; read = 1'b0;
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL glitch_data: got nonzero DATA required 0"); end
    bus_read(A_EDGE, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL glitch_edge: got %0h required 0", d); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    button[1] = 1'b0;
    repeat (12) tick();
    bus_write(A_EDGE, 32'h2);
    button[1] = 1'b1;
    repeat (12) tick();
    bus_read(A_EDGE, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL w1c_pre_clear: got %0h required 0", d); end
    button[1] = 1'b0;
    repeat (6) tick();
    bus_write(A_EDGE, 32'h2);
    bus_read(A_EDGE, d); checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL w1c_set_wins: got %0h required 2", d); end
    button[1] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_led();
    logic [31:0] d;
    bus_write(A_LED, 32'hA);
`ifdef LED_PWM_EN
    begin
      int hi;
      int bad;
      bus_write(A_DUTY, 32'h4);
      hi = 0; bad = 0;
      for (int k = 0; k < 16; k++) begin
        tick();
        if (led === 4'hA) hi++;
        else if (led !== 4'h0) bad++;
      end
      checks++;
      if (hi != 4 || bad != 0) begin failures++; $display("FAIL pwm_duty4: high=%0d bad=%0d required 4/0", hi, bad); end
      bus_write(A_DUTY, 32'h0);
      hi = 0;
      for (int k = 0; k < 16; k++) begin
        tick();
        if (led !== 4'h0) hi++;
      end
      checks++;
      if (hi != 0) begin failures++; $display("FAIL pwm_duty0: lit cycles=%0d required 0", hi); end
      bus_read(A_DUTY, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL duty_readback: got %0h required 0", d); end
      bus_write(A_DUTY, 32'hF);
    end
`else
    checks++;
    if (led !== 4'hA) begin failures++; $display("FAIL led_output: got %0h required a", led); end
    bus_write(A_DUTY, 32'h5);
    bus_read(A_DUTY, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL duty_disabled: got %0h required 0", d); end
`endif
    bus_read(A_LED, d); checks++;
    if (d !== 32'hA) begin failures++; $display("FAIL led_readback: got %0h required a", d); end
    // Read and write in the same cycle: read returns the old value
    address = A_LED; writedata = 32'hFFFF_FFF5; chipselect = 1'b1; write = 1'b1; read = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    checks++;
    if (readdata !== 32'hA) begin failures++; $display("FAIL rw_same_cycle: got %0h required a", readdata); end
    bus_read(A_LED, d); checks++;
    if (d !== 32'h5) begin failures++; $display("FAIL led_upper_bits: got %0h required 5", d); end
    bus_write(A_RSV, 32'hFFFF_FFFF);
    bus_read(A_RSV, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reserved_read: got %0h required 0", d); end
    bus_read(A_LED, d); checks++;
    if (d !== 32'h5) begin failures++; $display("FAIL reserved_write_ignored: got %0h required 5", d); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] d;
    bus_write(A_MASK, 32'h2);
    tick(); tick();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq: got %0b required 1", irq); end
    button[3] = 1'b0;
    repeat (4) tick();
    bus_read(A_LED, d);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (led !== 4'h0 || irq !== 1'b0 || readdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: led=%0h irq=%0b readdata=%0h required 0/0/0", led, irq, readdata);
    end
    @(posedge osc_clk);
    @(posedge osc_clk);
    #1;
    reset = 1'b0;
    wait_bit(A_DATA, 3, n);
    checks++;
    if (n != 8) begin failures++; $display("FAIL post_reset_latency: got %0d ticks required 8", n); end
    bus_read(A_EDGE, d); checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL post_reset_edge: got %0h required 8", d); end
    bus_read(A_MASK, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL post_reset_mask: got %0h required 0", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL post_reset_irq: got %0b required 0", irq); end
    button[3] = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_press();
    test_irq();
    test_glitch();
    test_w1c_collision();
    test_led();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
